// File: rtl/range_sweep_if.sv
// rtl/range_sweep_if.sv - control/sum bus between the sweep controller and the range-sum adder
//
// Ports (signals):
//   contr  [5:0]  {hi[2:0], lo[2:0]} range select, controller -> adder
//   clr           force adder sum to 0 (adder BTNU), controller -> adder
//   y_in   [7:0]  range sum for current contr, adder -> controller
// Modports: master = controller side, slave = adder side.
interface range_sweep_if;
  logic [5:0] contr;
  logic       clr;
  logic [7:0] y_in;

  modport master (output contr, output clr, input y_in);
  modport slave  (input contr, input clr, output y_in);
endinterface

// File: rtl/range_sweep_ctrl.sv
// rtl/range_sweep_ctrl.sv - sweeps all 36 (hi >= lo) ranges of the range-sum adder and keeps the best
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   start     begin a sweep (only looked at in IDLE)
//   bus       range_sweep_if.master: contr/clr out to the adder, y_in back
//   busy      high from start acceptance until the sweep's last sample
//   done      one-cycle pulse at sweep completion
//   best_sum  largest sum seen in the last completed sweep
//   best_hi   hi index of the first range producing best_sum
//   best_lo   lo index of the first range producing best_sum
//   pair_cnt  pairs sampled so far in the current/last sweep (0..36)
module range_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  range_sweep_if.master      bus,
  output logic               busy,
  output logic               done,
  output logic [7:0]         best_sum,
  output logic [2:0]         best_hi,
  output logic [2:0]         best_lo,
  output logic [5:0]         pair_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [5:0] contr_q;
  logic       clr_q;
  logic [2:0] hi;
  logic [2:0] lo;

  // The current pair lives directly in the registered control bus.
  assign hi        = contr_q[5:3];
  assign lo        = contr_q[2:0];
  assign bus.contr = contr_q;
  assign bus.clr   = clr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      contr_q  <= 6'd0;
      clr_q    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      best_sum <= 8'd0;
      best_hi  <= 3'd0;
      best_lo  <= 3'd0;
      pair_cnt <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          clr_q   <= 1'b1;
          busy    <= 1'b0;
          contr_q <= 6'd0;
          if (start) begin
            clr_q    <= 1'b0;
            busy     <= 1'b1;
            best_sum <= 8'd0;
            best_hi  <= 3'd0;
            best_lo  <= 3'd0;
            pair_cnt <= 6'd0;
            wait_cnt <= 4'd0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        SAMPLE: begin
          pair_cnt <= pair_cnt + 6'd1;
          wait_cnt <= 4'd0;
          // Strict compare: ties keep the earlier pair in sweep order.
          if (bus.y_in > best_sum) begin
            best_sum <= bus.y_in;
            best_hi  <= hi;
            best_lo  <= lo;
          end
          if (lo < hi) begin
            contr_q <= {hi, lo + 3'd1};
            state   <= WAIT;
          end else if (hi < 3'd7) begin
            contr_q <= {hi + 3'd1, 3'd0};
            state   <= WAIT;
          end else begin
            // Last pair (7,7): release the adder now, pulse done next cycle.
            busy    <= 1'b0;
            clr_q   <= 1'b1;
            contr_q <= 6'd0;
            state   <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
